// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: sequencer state encodings, exception causes and default trap vector.
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {RUN, MULDIV, DRAIN, VECTOR} state_e;
  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_TRAP = 2'b01;
  localparam logic [1:0] EXC_ILLEGAL = 2'b10;
  localparam logic [31:0] TRAP_VECTOR_DEF = 32'h0000_0080;
endpackage

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: load-use and free-list-empty hazard detection for the ID instruction.
module pipeline_hazard_unit #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      dec_valid,
  input  logic                      dec_rs_used,
  input  logic                      dec_rt_used,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rt_addr,
  input  logic                      dec_needs_preg,
  input  logic                      free_list_empty,
  input  logic                      ex_load,
  input  logic                      ex_wb_reg,
  input  logic [REG_ADDR_WIDTH-1:0] ex_write_addr,
  output logic                      hazard
);
  logic load_use;
  always_comb begin
    load_use = ex_load & ex_wb_reg & (ex_write_addr != '0) &
               ((dec_rs_used & (dec_rs_addr == ex_write_addr)) |
                (dec_rt_used & (dec_rt_addr == ex_write_addr)));
    hazard = dec_valid & (load_use | (dec_needs_preg & free_list_empty));
  end
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/redirect sequencer with mul/div hold and trap drain/vector entry.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_WIDTH = 6,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = ADDR_WIDTH'(TRAP_VECTOR_DEF)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dec_valid,
  input  logic                      dec_rs_used,
  input  logic                      dec_rt_used,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rt_addr,
  input  logic                      dec_needs_preg,
  input  logic                      free_list_empty,
  input  logic                      ex_load,
  input  logic                      ex_wb_reg,
  input  logic [REG_ADDR_WIDTH-1:0] ex_write_addr,
  input  logic                      ex_muldiv_start,
  input  logic                      ex_branch_taken,
  input  logic [ADDR_WIDTH-1:0]     ex_branch_target,
  input  logic                      ex_trap,
  input  logic                      ex_illegal,
  input  logic [ADDR_WIDTH-1:0]     ex_pc,
  input  logic                      mem_busy,
  input  logic                      active_list_empty,
  output logic                      stall_fetch,
  output logic                      stall_f2d,
  output logic                      stall_d2e,
  output logic                      stall_e2m,
  output logic                      flush_f2d,
  output logic                      flush_d2e,
  output logic                      flush_e2m,
  output logic                      redirect_valid,
  output logic [ADDR_WIDTH-1:0]     redirect_pc,
  output logic [ADDR_WIDTH-1:0]     epc,
  output logic [1:0]                exc_cause,
  output logic                      muldiv_busy
);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(MULDIV_CYCLES - 1);
  state_e state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] epc_q, epc_d;
  logic [1:0] cause_q, cause_d;
  logic hazard;
  pipeline_hazard_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_hazard (
    .dec_valid(dec_valid),
    .dec_rs_used(dec_rs_used),
    .dec_rt_used(dec_rt_used),
    .dec_rs_addr(dec_rs_addr),
    .dec_rt_addr(dec_rt_addr),
    .dec_needs_preg(dec_needs_preg),
    .free_list_empty(free_list_empty),
    .ex_load(ex_load),
    .ex_wb_reg(ex_wb_reg),
    .ex_write_addr(ex_write_addr),
    .hazard(hazard)
  );
  // The RUN cycle that sees the start counts as the first stalled cycle, so MULDIV
  // leaves on the edge where the counter reaches zero: MULDIV_CYCLES stalls total.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    epc_d = epc_q;
    cause_d = cause_q;
    stall_fetch = 1'b0;
    stall_f2d = 1'b0;
    stall_d2e = 1'b0;
    stall_e2m = 1'b0;
    flush_f2d = 1'b0;
    flush_d2e = 1'b0;
    flush_e2m = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (mem_busy) begin
            stall_fetch = 1'b1;
            stall_f2d = 1'b1;
            stall_d2e = 1'b1;
            stall_e2m = 1'b1;
          end else if (ex_trap | ex_illegal) begin
            flush_f2d = 1'b1;
            flush_d2e = 1'b1;
            flush_e2m = 1'b1;
            epc_d = ex_pc;
            cause_d = ex_illegal ? EXC_ILLEGAL : EXC_TRAP;
            state_d = DRAIN;
          end else if (ex_branch_taken) begin
            flush_f2d = 1'b1;
            flush_d2e = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc = ex_branch_target;
          end else if (ex_muldiv_start) begin
            stall_fetch = 1'b1;
            stall_f2d = 1'b1;
            stall_d2e = 1'b1;
            flush_e2m = 1'b1;
            cnt_d = CNT_LOAD;
            state_d = MULDIV;
          end else if (hazard) begin
            stall_fetch = 1'b1;
            stall_f2d = 1'b1;
            flush_d2e = 1'b1;
          end
        end
        MULDIV: begin
          if (cnt_q != '0) begin
            stall_fetch = 1'b1;
            stall_f2d = 1'b1;
            stall_d2e = 1'b1;
            stall_e2m = mem_busy;
            flush_e2m = !mem_busy;
            cnt_d = cnt_q - CNT_ONE;
            state_d = (cnt_q == CNT_ONE) ? RUN : MULDIV;
          end else begin
            state_d = RUN;
          end
        end
        DRAIN: begin
          stall_fetch = 1'b1;
          flush_f2d = 1'b1;
          flush_d2e = 1'b1;
          stall_e2m = mem_busy;
          state_d = (active_list_empty & !mem_busy) ? VECTOR : DRAIN;
        end
        VECTOR: begin
          redirect_valid = 1'b1;
          redirect_pc = TRAP_VECTOR;
          flush_f2d = 1'b1;
          state_d = RUN;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q <= '0;
      epc_q <= '0;
      cause_q <= EXC_NONE;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      epc_q <= epc_d;
      cause_q <= cause_d;
    end
  end
  always_comb begin
    epc = epc_q;
    exc_cause = cause_q;
    muldiv_busy = (state_q == MULDIV);
  end
endmodule
